// File: rtl/pixel_pattern_source.sv
// RGB565 test-pattern source feeding the ST7735 driver over its WRITE_EN / IS_BUSY handshake.
// Optional build macro PATTERN_SCROLL_EN scrolls modes 1-3 left by one pixel per frame.
module pixel_pattern_source #(
    parameter int unsigned WIDTH      = 128,
    parameter int unsigned HEIGHT     = 160,
    parameter int unsigned CHECK_LOG2 = 3
) (
    input  logic                      SYSTEM_CLK,
    input  logic                      RESET_N,
    input  logic                      LCD_READY,
    input  logic                      IS_BUSY,
    input  logic [1:0]                MODE,
    input  logic [15:0]               SOLID_COLOR,
    output logic [15:0]               COLOR_PIXEL,
    output logic                      WRITE_EN,
    output logic                      FRAME_START,
    output logic                      FRAME_DONE,
    output logic [$clog2(WIDTH)-1:0]  X_POS,
    output logic [$clog2(HEIGHT)-1:0] Y_POS
);

    localparam int unsigned XW    = $clog2(WIDTH);
    localparam int unsigned YW    = $clog2(HEIGHT);
    localparam int unsigned BAR_W = WIDTH / 8;
    localparam int unsigned BW    = (BAR_W > 1) ? $clog2(BAR_W) : 1;

    typedef enum logic [1:0] {StIdle, StPresent, StWait} state_e;

    state_e          state_q, state_d;
    logic [XW-1:0]   x_q, x_d, px_q, px_d, rpx_q, rpx_d;
    logic [YW-1:0]   y_q, y_d;
    logic [BW-1:0]   bpos_q, bpos_d, rbpos_q, rbpos_d;
    logic [2:0]      bidx_q, bidx_d, rbidx_q, rbidx_d;
    logic [7:0]      frame_q, frame_d;
    logic [1:0]      mode_q, mode_d;
    logic [15:0]     pix_q, pix_d;
    logic            busy_q;
    logic            accept, done, load, last_px;
    logic [4:0]      blue;

    assign accept  = IS_BUSY & ~busy_q;
    assign done    = ~IS_BUSY & busy_q;
    assign last_px = (x_q == XW'(WIDTH - 1)) && (y_q == YW'(HEIGHT - 1));

    function automatic logic [15:0] pattern(input logic [1:0] m, input logic [15:0] solid,
                                            input logic [2:0] bidx, input logic [XW-1:0] px,
                                            input logic [YW-1:0] py, input logic [4:0] b);
        logic [15:0] p;
        case (m)
            2'd0: p = solid;
            2'd1: begin
                case (bidx)
                    3'd0:    p = 16'hFFFF;
                    3'd1:    p = 16'hFFE0;
                    3'd2:    p = 16'h07FF;
                    3'd3:    p = 16'h07E0;
                    3'd4:    p = 16'hF81F;
                    3'd5:    p = 16'hF800;
                    3'd6:    p = 16'h001F;
                    default: p = 16'h0000;
                endcase
            end
            2'd2:    p = {5'(px >> 2), 6'(py >> 2), b};
            default: p = (1'(px >> CHECK_LOG2) ^ 1'(py >> CHECK_LOG2)) ? 16'hFFFF : 16'h0000;
        endcase
        return p;
    endfunction

    always_ff @(posedge SYSTEM_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (LCD_READY) state_d = StPresent;
            StPresent: if (accept) state_d = StWait;
            StWait:    if (done) state_d = StPresent;
            default:   state_d = StIdle;
        endcase
        if (!LCD_READY) state_d = StIdle;
    end

    // Datapath: raster position, bar counters (which follow the possibly scrolled x) and pixel.
    always_comb begin
        x_d     = x_q;
        y_d     = y_q;
        px_d    = px_q;
        bpos_d  = bpos_q;
        bidx_d  = bidx_q;
        rpx_d   = rpx_q;
        rbpos_d = rbpos_q;
        rbidx_d = rbidx_q;
        frame_d = frame_q;
        mode_d  = mode_q;
        pix_d   = pix_q;
        load    = 1'b0;
        blue    = 5'd0;
        if (!LCD_READY) begin
            x_d    = '0;
            y_d    = '0;
            px_d   = rpx_q;
            bpos_d = rbpos_q;
            bidx_d = rbidx_q;
        end else if (state_q == StIdle) begin
            load = 1'b1;
            if (x_q == '0 && y_q == '0) mode_d = MODE;
        end else if (state_q == StWait && done) begin
            load = 1'b1;
            if (x_q == XW'(WIDTH - 1)) begin
                x_d    = '0;
                px_d   = rpx_q;
                bpos_d = rbpos_q;
                bidx_d = rbidx_q;
                if (y_q == YW'(HEIGHT - 1)) begin
                    y_d     = '0;
                    frame_d = frame_q + 8'd1;
                    mode_d  = MODE;
`ifdef PATTERN_SCROLL_EN
                    // Row-start position tracks frame_cnt mod WIDTH, restarting when it wraps.
                    if (frame_d == 8'd0) begin
                        rpx_d   = '0;
                        rbpos_d = '0;
                        rbidx_d = '0;
                    end else begin
                        rpx_d = (rpx_q == XW'(WIDTH - 1)) ? '0 : rpx_q + XW'(1);
                        if (rbpos_q == BW'(BAR_W - 1)) begin
                            rbpos_d = '0;
                            rbidx_d = rbidx_q + 3'd1;
                        end else begin
                            rbpos_d = rbpos_q + BW'(1);
                        end
                    end
                    px_d   = rpx_d;
                    bpos_d = rbpos_d;
                    bidx_d = rbidx_d;
`endif
                end else begin
                    y_d = y_q + YW'(1);
                end
            end else begin
                x_d  = x_q + XW'(1);
                px_d = (px_q == XW'(WIDTH - 1)) ? '0 : px_q + XW'(1);
                if (bpos_q == BW'(BAR_W - 1)) begin
                    bpos_d = '0;
                    bidx_d = bidx_q + 3'd1;
                end else begin
                    bpos_d = bpos_q + BW'(1);
                end
            end
        end
`ifdef PATTERN_SCROLL_EN
        blue = frame_d[7:3];
`endif
        if (load) pix_d = pattern(mode_d, SOLID_COLOR, bidx_d, px_d, y_d, blue);
    end

    always_ff @(posedge SYSTEM_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            x_q     <= '0;
            y_q     <= '0;
            px_q    <= '0;
            bpos_q  <= '0;
            bidx_q  <= '0;
            rpx_q   <= '0;
            rbpos_q <= '0;
            rbidx_q <= '0;
            frame_q <= '0;
            mode_q  <= '0;
            pix_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            x_q     <= x_d;
            y_q     <= y_d;
            px_q    <= px_d;
            bpos_q  <= bpos_d;
            bidx_q  <= bidx_d;
            rpx_q   <= rpx_d;
            rbpos_q <= rbpos_d;
            rbidx_q <= rbidx_d;
            frame_q <= frame_d;
            mode_q  <= mode_d;
            pix_q   <= pix_d;
            busy_q  <= IS_BUSY;
        end
    end

    always_comb begin
        COLOR_PIXEL = pix_q;
        X_POS       = x_q;
        Y_POS       = y_q;
        WRITE_EN    = (state_q == StPresent);
        FRAME_START = (state_q == StPresent) && accept && (x_q == '0) && (y_q == '0);
        FRAME_DONE  = (state_q == StWait) && done && LCD_READY && last_px;
    end

endmodule

// File: tb/tb_pixel_pattern_source.sv
// Scoreboard bench for pixel_pattern_source on a reduced 64x24 frame with a handshake driver model.
module tb_pixel_pattern_source;

    localparam int W    = 64;
    localparam int H    = 24;
    localparam int CL   = 3;
    localparam int NPIX = W * H;
    localparam int NVEC = 17;

    logic        clk = 1'b0;
    logic        rst_n, lcd_ready, is_busy;
    logic [1:0]  mode;
    logic [15:0] solid;
    logic [15:0] pix;
    logic        we, fstart, fdone;
    logic [5:0]  xpos;
    logic [4:0]  ypos;

    always #5 clk = ~clk;

    pixel_pattern_source #(.WIDTH(W), .HEIGHT(H), .CHECK_LOG2(CL)) dut (
        .SYSTEM_CLK (clk),
        .RESET_N    (rst_n),
        .LCD_READY  (lcd_ready),
        .IS_BUSY    (is_busy),
        .MODE       (mode),
        .SOLID_COLOR(solid),
        .COLOR_PIXEL(pix),
        .WRITE_EN   (we),
        .FRAME_START(fstart),
        .FRAME_DONE (fdone),
        .X_POS      (xpos),
        .Y_POS      (ypos)
    );

    typedef struct {int x; int y; logic [1:0] m; logic [15:0] pix;} sb_t;
    typedef struct {logic [1:0] m; int x; int y; logic [15:0] pix;} vec_t;

    sb_t         sb[$];
    vec_t        vt[NVEC];
    int          hit[NVEC];
    int          vectors = 0;
    int          miscompares = 0;
    int          ex, ey, fc;
    logic [1:0]  em;
    logic [15:0] bars[8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                             16'hF81F, 16'hF800, 16'h001F, 16'h0000};

    function automatic logic [15:0] model(input logic [1:0] m, input int x, input int y);
        int         xm;
        logic [4:0] b;
        xm = x;
        b  = 5'd0;
`ifdef PATTERN_SCROLL_EN
        xm = (x + (fc % 256)) % W;
        b  = 5'((fc % 256) >> 3);
`endif
        case (m)
            2'd0:    return solid;
            2'd1:    return bars[xm / (W / 8)];
            2'd2:    return {5'(xm >> 2), 6'(y >> 2), b};
            default: return ((((xm >> CL) ^ (y >> CL)) & 1) != 0) ? 16'hFFFF : 16'h0000;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_exp();
        sb.push_back('{ex, ey, em, model(em, ex, ey)});
    endtask

    task automatic start_frame();
        ex = 0;
        ey = 0;
        em = mode;
        push_exp();
    endtask

    task automatic advance();
        if (ex == W - 1) begin
            ex = 0;
            if (ey == H - 1) begin
                ey = 0;
                fc++;
                em = mode;
            end else begin
                ey++;
            end
        end else begin
            ex++;
        end
        push_exp();
    endtask

    task automatic wait_we(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (we === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) check("write_en_timeout", 32'd0, 32'd1);
    endtask

    task automatic pop_and_compare(output sb_t e, output bit ok);
        wait_we(ok);
        if (!ok) return;
        if (sb.size() == 0) begin
            check("scoreboard_empty", 32'd0, 32'd1);
            ok = 1'b0;
            return;
        end
        e = sb.pop_front();
        check("pixel", pix, e.pix);
        check("x_pos", xpos, e.x);
        check("y_pos", ypos, e.y);
`ifndef PATTERN_SCROLL_EN
        for (int i = 0; i < NVEC; i++) begin
            if (vt[i].m == e.m && vt[i].x == e.x && vt[i].y == e.y) begin
                check("table_pixel", pix, vt[i].pix);
                hit[i]++;
            end
        end
`endif
    endtask

    // One full handshake: accept, hold busy for busy_len cycles, done, then expect the next pixel.
    task automatic serve(input int busy_len);
        sb_t e;
        bit  ok;
        bit  last;
        pop_and_compare(e, ok);
        if (!ok) return;
        last = (e.x == W - 1) && (e.y == H - 1);
        is_busy = 1'b1;
        #1 check("frame_start", fstart, (e.x == 0) && (e.y == 0));
        for (int i = 0; i < busy_len; i++) begin
            @(negedge clk);
            if (i == 0) check("we_low_in_wait", we, 1'b0);
        end
        is_busy = 1'b0;
        advance();
        #1 check("frame_done", fdone, last);
        @(negedge clk);
        check("next_pixel_latency", we, 1'b1);
    endtask

    task automatic run_frame(input int busy_len, input int n, input logic [1:0] nxt, input int at);
        for (int i = 0; i < n; i++) begin
            if (i == at) mode = nxt;
            serve(busy_len);
        end
    endtask

    initial begin
        sb_t e;
        bit  ok;
        vt[0]  = '{2'd1, 0, 0, 16'hFFFF};
        vt[1]  = '{2'd1, 7, 0, 16'hFFFF};
        vt[2]  = '{2'd1, 8, 0, 16'hFFE0};
        vt[3]  = '{2'd1, 15, 5, 16'hFFE0};
        vt[4]  = '{2'd1, 16, 0, 16'h07FF};
        vt[5]  = '{2'd1, 40, 2, 16'hF800};
        vt[6]  = '{2'd1, 63, 23, 16'h0000};
        vt[7]  = '{2'd2, 0, 0, 16'h0000};
        vt[8]  = '{2'd2, 63, 0, 16'h7800};
        vt[9]  = '{2'd2, 0, 23, 16'h00A0};
        vt[10] = '{2'd2, 63, 23, 16'h78A0};
        vt[11] = '{2'd2, 4, 4, 16'h0820};
        vt[12] = '{2'd3, 0, 0, 16'h0000};
        vt[13] = '{2'd3, 8, 0, 16'hFFFF};
        vt[14] = '{2'd3, 8, 8, 16'h0000};
        vt[15] = '{2'd3, 63, 23, 16'hFFFF};
        vt[16] = '{2'd0, 33, 11, 16'hF800};
        for (int i = 0; i < NVEC; i++) hit[i] = 0;

        rst_n = 1'b0; lcd_ready = 1'b0; is_busy = 1'b0; mode = 2'd1; solid = 16'hF800; fc = 0;
        repeat (2) @(negedge clk);
        check("reset_we", we, 1'b0);
        check("reset_pixel", pix, 16'h0000);
        check("reset_frame_start", fstart, 1'b0);
        check("reset_frame_done", fdone, 1'b0);
        check("reset_x", xpos, 0);
        check("reset_y", ypos, 0);
        rst_n = 1'b1;
        @(negedge clk);
        lcd_ready = 1'b1;
        start_frame();

        run_frame(4, NPIX, 2'd0, NPIX - 1);    // bars, next frame solid
        run_frame(2, NPIX, 2'd3, NPIX / 2);    // solid; mid-frame switch to checkerboard
        run_frame(2, NPIX, 2'd2, NPIX / 2);    // checkerboard
        run_frame(1, NPIX, 2'd0, NPIX / 2);    // gradient, back-to-back accept/done
        run_frame(1, 3 * W + 5, 2'd0, -1);     // solid up to (5,3)

        // Drop LCD_READY while waiting on pixel (5,3); driver keeps IS_BUSY high throughout.
        pop_and_compare(e, ok);
        is_busy = 1'b1;
        @(negedge clk);
        lcd_ready = 1'b0;
        @(negedge clk);
        check("ready_drop_we", we, 1'b0);
        check("ready_drop_x", xpos, 0);
        check("ready_drop_y", ypos, 0);
        mode = 2'd3;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("ready_low_frame_done", fdone, 1'b0);
        end
        sb.delete();
        lcd_ready = 1'b1;
        start_frame();
        @(negedge clk);
        check("ready_resume_we", we, 1'b1);
        for (int i = 0; i < 3; i++) begin
            check("busy_held_x", xpos, 0);
            check("busy_held_frame_start", fstart, 1'b0);
            @(negedge clk);
        end
        is_busy = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("busy_fall_we", we, 1'b1);
            check("busy_fall_x", xpos, 0);
        end
        run_frame(2, 8, 2'd0, -1);

        // Async reset while presenting (8,0), which is white in the checkerboard.
        pop_and_compare(e, ok);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_we", we, 1'b0);
        check("async_reset_pixel", pix, 16'h0000);
        check("async_reset_x", xpos, 0);
        @(negedge clk);
        rst_n = 1'b1;
        sb.delete();
        fc = 0;
        start_frame();
        run_frame(2, W + 2, 2'd0, -1);

`ifndef PATTERN_SCROLL_EN
        for (int i = 0; i < NVEC; i++) check("table_entry_seen", hit[i] > 0, 1'b1);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pixel_pattern_source.md
Name: pixel_pattern_source

Overview:
Upstream pixel producer for the ST7735 driver. Generates full frames of RGB565 test patterns in raster order (x fastest, then y) and hands them to the driver one pixel at a time over the driver's WRITE_EN / IS_BUSY handshake. Its advance logic is fully synchronous to SYSTEM_CLK; it never clocks on IS_BUSY edges.

Parameters:
WIDTH, 128, active columns per frame
HEIGHT, 160, active rows per frame
CHECK_LOG2, 3, checkerboard square size is 2^CHECK_LOG2 pixels

Ports:
SYSTEM_CLK  input  1  system clock, all logic on rising edge
RESET_N  input  1  asynchronous active-low reset
LCD_READY  input  1  driver initialised and accepting pixels
IS_BUSY  input  1  driver is shifting a pixel
MODE  input  2  pattern select: 0 solid, 1 colour bars, 2 gradient, 3 checkerboard
SOLID_COLOR  input  16  RGB565 value used in mode 0
COLOR_PIXEL  output  16  current RGB565 pixel, registered
WRITE_EN  output  1  pixel on COLOR_PIXEL is valid
FRAME_START  output  1  one-cycle pulse when pixel (0,0) is accepted
FRAME_DONE  output  1  one-cycle pulse when pixel (WIDTH-1,HEIGHT-1) completes
X_POS  output  clog2(WIDTH)  column of COLOR_PIXEL
Y_POS  output  clog2(HEIGHT)  row of COLOR_PIXEL

Behaviour:
- Reset (async, RESET_N=0): state IDLE; x=0, y=0, frame_cnt=0; COLOR_PIXEL=16'h0000; WRITE_EN=0; FRAME_START=0; FRAME_DONE=0; latched mode=0.
- busy_q = IS_BUSY registered each cycle. accept = IS_BUSY & ~busy_q. done = ~IS_BUSY & busy_q.
- FSM:
  - IDLE: WRITE_EN=0. If LCD_READY=1, latch MODE when x=0 and y=0, load COLOR_PIXEL for (x,y), then go to PRESENT on the next cycle.
  - PRESENT: WRITE_EN=1; COLOR_PIXEL held stable. On accept: go to WAIT. If (x,y)=(0,0), pulse FRAME_START in the same cycle.
  - WAIT: WRITE_EN=0. On done: advance x; at x=WIDTH-1, wrap x to 0 and increment y.
    - At the last pixel: pulse FRAME_DONE, wrap y to 0, increment frame_cnt (8-bit, wraps at 255->0), and latch MODE for the next frame.
    - Compute the new COLOR_PIXEL in this cycle; the following cycle is PRESENT.
- Latency: exactly 1 cycle from done to WRITE_EN re-asserting with the next pixel.
- MODE and SOLID_COLOR are sampled only at frame start. Mid-frame changes take effect on the next frame.
  - Exception: SOLID_COLOR is read live in mode 0.
- Patterns, evaluated at (x,y):
  - Mode 0: SOLID_COLOR.
  - Mode 1: 8 equal vertical bars, bar width WIDTH/8 (WIDTH must be a multiple of 8). Bar index comes from a bar counter, not a multiplier. Order: FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000.
  - Mode 2: R = (x>>2)[4:0], G = (y>>2)[5:0], B = 0. Results are truncated, not saturated.
  - Mode 3: ((x>>CHECK_LOG2) ^ (y>>CHECK_LOG2)) bit0 = 1 gives FFFF, else 0000.
- LCD_READY falling in any state:
  - Go to IDLE next cycle; WRITE_EN=0; x=y=0.
  - A pixel already accepted is abandoned; no FRAME_DONE is issued.
- IS_BUSY already high on entry to PRESENT: no accept until it falls and rises again. This prevents double-counting.
- accept and done in consecutive cycles are both honoured.
- X_POS and Y_POS track COLOR_PIXEL exactly.

Optional Feature:
PATTERN_SCROLL_EN
- Defined: the x used by modes 1-3 becomes (x + frame_cnt) mod WIDTH, so the pattern scrolls left 1 pixel per frame. In mode 2, B = frame_cnt[7:3]. X_POS still reports the unshifted raster x.
- Undefined: no offset; B=0 in mode 2; frame_cnt is still kept for FRAME_* logic.

Test Plan:
- Reset then LCD_READY=1, MODE=1, driver model busy 4 cycles per pixel. Expect pixels:
  - x=0..15 = FFFF
  - x=16..31 = FFE0
  - x=112..127 = 0000
  - FRAME_START once at the first accept
  - FRAME_DONE after exactly 20480 pixels
- MODE=0, SOLID_COLOR=F800. Expect every pixel F800. Change MODE to 3 mid-frame: the current frame stays F800; the next frame gives (0,0)=0000, (8,0)=FFFF, (8,8)=0000.
- MODE=2. Expect (0,0)=0000, (127,0)=F800, (0,159)=04E0, (127,159)=FCE0.
- Drop LCD_READY at pixel (5,3) while in WAIT. Expect WRITE_EN=0 the next cycle. On LCD_READY re-assert, the first pixel is (0,0) with a FRAME_START pulse, and no FRAME_DONE is emitted.
- Assert RESET_N=0 asynchronously mid-PRESENT. Expect WRITE_EN and COLOR_PIXEL at 0 without waiting for a clock edge.
- Driver holds IS_BUSY=1 when PRESENT is entered. Expect no advance until a full fall-then-rise-then-fall sequence; X_POS stays put.
- With PATTERN_SCROLL_EN, MODE=1. Expect frame 1 pixel x=15 = FFE0.
